// File: rtl/generic_sram_2p_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : generic_sram_2p_pkg
//  Description : Default geometry for the generic true dual-port SRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
package generic_sram_2p_pkg;

  // Default geometry matches the 512x32 BRAM wrapper
  localparam int c_ABITS_DEF = 9;
  localparam int c_DBITS_DEF = 32;

endpackage : generic_sram_2p_pkg
`default_nettype wire

// File: rtl/generic_sram_2p_if.sv
`default_nettype none
// ============================================================================
//  Module      : generic_sram_2p_if
//  Description : Bus bundle for both ports of the dual-port SRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
interface generic_sram_2p_if
  import generic_sram_2p_pkg::*;
#(
  parameter int abits = c_ABITS_DEF,
  parameter int dbits = c_DBITS_DEF
);

  // Port 0
  logic [abits-1:0] a0;
  logic [dbits-1:0] d0;
  logic             we0;
  logic [dbits-1:0] q0;

  // Port 1
  logic [abits-1:0] a1;
  logic [dbits-1:0] d1;
  logic             we1;
  logic [dbits-1:0] q1;

  // Requester side: drives addresses, data and strobes
  modport master (
    output a0, d0, we0,
    output a1, d1, we1,
    input  q0, q1
  );

  // Memory side: returns registered read data
  modport slave (
    input  a0, d0, we0,
    input  a1, d1, we1,
    output q0, q1
  );

endinterface : generic_sram_2p_if
`default_nettype wire

// File: rtl/generic_sram_2p_port.sv
`default_nettype none
// ============================================================================
//  Module      : generic_sram_port
//  Description : One SRAM port: gated write enable and reset-able read
//                register. The storage array itself lives in the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module generic_sram_port
  import generic_sram_2p_pkg::*;
#(
  parameter int dbits = c_DBITS_DEF
) (
  input  wire logic             clk,
  input  wire logic             rstn,
  input  wire logic             i_we,
  input  wire logic [dbits-1:0] i_rdata,
  output logic                  o_wr_en,
  output logic [dbits-1:0]      o_q
);

  logic [dbits-1:0] r_q;

  // Writes are suppressed while reset is held; the array keeps its contents
  assign o_wr_en = i_we & rstn;

  // Read register: captures the pre-write array word, cleared asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= '0;
    end else begin
      r_q <= i_rdata;
    end
  end

  assign o_q = r_q;

endmodule : generic_sram_port
`default_nettype wire

// File: rtl/generic_sram_2p.sv
`default_nettype none
// ============================================================================
//  Module      : generic_sram_2p
//  Description : Technology-independent true dual-port synchronous SRAM.
//                Read-first on both ports; port 1 wins a write collision.
//  Revision    : 1.0 - initial release
// ============================================================================
module generic_sram_2p
  import generic_sram_2p_pkg::*;
#(
  parameter int abits = c_ABITS_DEF,
  parameter int dbits = c_DBITS_DEF
) (
  input  wire logic          clk,
  input  wire logic          rstn,
  generic_sram_2p_if.slave   bus
);

  localparam int c_DEPTH = 1 << abits;

  // No reset on the array so FPGA flows can map it to block RAM
  logic [dbits-1:0] r_mem [c_DEPTH];

  logic [dbits-1:0] w_rd0;
  logic [dbits-1:0] w_rd1;
  logic             w_wr0;
  logic             w_wr1;

  // Both ports sample the current contents every cycle (read-first)
  assign w_rd0 = r_mem[bus.a0];
  assign w_rd1 = r_mem[bus.a1];

  generic_sram_port #(.dbits(dbits)) u_port0 (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (bus.we0),
    .i_rdata (w_rd0),
    .o_wr_en (w_wr0),
    .o_q     (bus.q0)
  );

  generic_sram_port #(.dbits(dbits)) u_port1 (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (bus.we1),
    .i_rdata (w_rd1),
    .o_wr_en (w_wr1),
    .o_q     (bus.q1)
  );

  // Array update: port 1 is written last so it wins on an address collision
  always_ff @(posedge clk) begin
    if (w_wr0) begin
      r_mem[bus.a0] <= bus.d0;
    end
    if (w_wr1) begin
      r_mem[bus.a1] <= bus.d1;
    end
  end

endmodule : generic_sram_2p
`default_nettype wire

// File: tb/tb_generic_sram_2p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_generic_sram_2p
//  Description : Self-checking bench for generic_sram_2p against an array
//                model of the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_generic_sram_2p;

  localparam int AB    = 9;
  localparam int DB    = 32;
  localparam int DEPTH = 1 << AB;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  generic_sram_2p_if #(.abits(AB), .dbits(DB)) bus ();

  generic_sram_2p #(.abits(AB), .dbits(DB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference memory; X marks words never written
  logic [DB-1:0] mdl [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: apply inputs, let the edge happen, update model, compare q
  task automatic step(input logic [AB-1:0] x0, input logic [DB-1:0] v0, input logic w0,
                      input logic [AB-1:0] x1, input logic [DB-1:0] v1, input logic w1);
    logic [DB-1:0] e0, e1;
    bus.a0 = x0; bus.d0 = v0; bus.we0 = w0;
    bus.a1 = x1; bus.d1 = v1; bus.we1 = w1;
    @(posedge clk);
    if (rstn) begin
      e0 = mdl[x0];
      e1 = mdl[x1];
      if (w0) mdl[x0] = v0;
      if (w1) mdl[x1] = v1;
    end else begin
      e0 = '0;
      e1 = '0;
    end
    #1;
    if (!$isunknown(e0)) chk("q0", bus.q0, e0);
    if (!$isunknown(e1)) chk("q1", bus.q1, e1);
  endtask

  task automatic rand_step(input bit narrow);
    logic [AB-1:0] x0, x1;
    x0 = narrow ? AB'($urandom_range(0, 15)) : AB'($urandom_range(0, DEPTH-1));
    x1 = narrow ? AB'($urandom_range(0, 15)) : AB'($urandom_range(0, DEPTH-1));
    step(x0, $urandom, 1'($urandom), x1, $urandom, 1'($urandom));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl[i] = 'x;
    bus.a0 = '0; bus.d0 = '0; bus.we0 = 1'b0;
    bus.a1 = '0; bus.d1 = '0; bus.we1 = 1'b0;

    // Reset from time zero: outputs cleared, writes ignored
    #1;
    chk("rst_q0", bus.q0, '0);
    chk("rst_q1", bus.q1, '0);
    for (int i = 0; i < 3; i++) rand_step(1'b0);
    rstn = 1'b1;

    // Sweep: port 0 fills the memory, port 1 trails one address behind
    for (int i = 0; i < DEPTH; i++) begin
      step(AB'(i), DB'(i * 3), 1'b1, AB'(i - 1), $urandom, 1'b0);
      if (i > 0) chk("sweep_q1", bus.q1, DB'((i - 1) * 3));
    end

    // Basic write then read from both ports
    step(AB'(5), 32'hDEADBEEF, 1'b1, AB'(9), '0, 1'b0);
    step(AB'(5), '0, 1'b0, AB'(5), '0, 1'b0);
    chk("basic_q0", bus.q0, 32'hDEADBEEF);
    chk("basic_q1", bus.q1, 32'hDEADBEEF);

    // Read-first on the same port, old data on the other port
    step(AB'(3), 32'h11111111, 1'b1, AB'(0), '0, 1'b0);
    step(AB'(3), 32'h22222222, 1'b1, AB'(3), '0, 1'b0);
    chk("rdfirst_q0", bus.q0, 32'h11111111);
    chk("xport_q1", bus.q1, 32'h11111111);
    step(AB'(3), '0, 1'b0, AB'(3), '0, 1'b0);
    chk("rdfirst_new", bus.q0, 32'h22222222);

    // Collision: port 1 wins
    step(AB'(7), 32'hAAAA0000, 1'b1, AB'(7), 32'h0000BBBB, 1'b1);
    step(AB'(7), '0, 1'b0, AB'(7), '0, 1'b0);
    chk("coll_q0", bus.q0, 32'h0000BBBB);
    chk("coll_q1", bus.q1, 32'h0000BBBB);

    // Address boundaries, no aliasing
    step(AB'(0), 32'hA5A5F00D, 1'b1, AB'(DEPTH-1), 32'h5A5AC0DE, 1'b1);
    step(AB'(0), '0, 1'b0, AB'(DEPTH-1), '0, 1'b0);
    chk("bnd_lo_q0", bus.q0, 32'hA5A5F00D);
    chk("bnd_hi_q1", bus.q1, 32'h5A5AC0DE);
    step(AB'(DEPTH-1), '0, 1'b0, AB'(0), '0, 1'b0);
    chk("bnd_hi_q0", bus.q0, 32'h5A5AC0DE);
    chk("bnd_lo_q1", bus.q1, 32'hA5A5F00D);

    // Mid-run reset: immediate clear, writes blocked, contents kept
    rstn = 1'b0;
    #1;
    chk("mrst_q0", bus.q0, '0);
    chk("mrst_q1", bus.q1, '0);
    step(AB'(5), 32'h0BAD0BAD, 1'b1, AB'(7), 32'h0BAD0BAD, 1'b1);
    for (int i = 0; i < 4; i++) rand_step(1'b1);
    rstn = 1'b1;
    step(AB'(5), '0, 1'b0, AB'(7), '0, 1'b0);
    chk("keep_q0", bus.q0, 32'hDEADBEEF);
    chk("keep_q1", bus.q1, 32'h0000BBBB);

    // Random traffic, half of it in a small window to force collisions
    for (int i = 0; i < 400; i++) rand_step(i[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_generic_sram_2p
`default_nettype wire
